// File: rtl/soc_bram_pkg.sv
// Shared encodings for the BRAM arbiter slice: FSM states and requester indices.
package soc_bram_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    // The round-robin pointer always moves to the requester that just lost.
    function automatic logic other_req(input logic req);
        return ~req;
    endfunction

endpackage

// File: rtl/soc_rr_arb2.sv
// Combinational 2-way round-robin grant picker; ptr breaks ties when both request.
// Latency: zero (pure combinational). Backpressure: none, caller decides when to sample.
// Bit 0 of valid is requester A, bit 1 is requester B; grant uses the same index.
module soc_rr_arb2 (
    input  logic [1:0] valid,
    input  logic       ptr,
    output logic       grant,
    output logic       any
);

    always_comb begin
        any   = |valid;
        grant = (valid == 2'b11) ? ptr : valid[1];
    end

endmodule

// File: rtl/soc_bram_arb.sv
// Round-robin arbiter sharing one soc_bram_ctl between fetch (A) and load/store (B).
// Latency: grant on the sampling edge, done pulse one edge after m_done, then one idle cycle.
// Backpressure: requesters hold valid until their done; one transaction in flight at a time.
module soc_bram_arb #(
    parameter int addr_width = 8,
    parameter int data_width = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  a_valid,
    input  logic                  a_rw,
    input  logic [addr_width-1:0] a_addr,
    input  logic [data_width-1:0] a_dwrite,
    output logic [data_width-1:0] a_dread,
    output logic                  a_done,
    input  logic                  b_valid,
    input  logic                  b_rw,
    input  logic [addr_width-1:0] b_addr,
    input  logic [data_width-1:0] b_dwrite,
    output logic [data_width-1:0] b_dread,
    output logic                  b_done,
    output logic                  m_valid,
    output logic                  m_rw,
    output logic [addr_width-1:0] m_addr,
    output logic [data_width-1:0] m_dwrite,
    input  logic [data_width-1:0] m_dread,
    input  logic                  m_done
);
    import soc_bram_pkg::*;

    logic [1:0] state;
    logic       ptr;
    logic       gnt_q;
    logic       pick;
    logic       pick_any;

    soc_rr_arb2 u_pick (
        .valid ({b_valid, a_valid}),
        .ptr   (ptr),
        .grant (pick),
        .any   (pick_any)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            ptr      <= REQ_A;
            gnt_q    <= REQ_A;
            m_valid  <= 1'b0;
            m_rw     <= 1'b0;
            m_addr   <= '0;
            m_dwrite <= '0;
            a_dread  <= '0;
            b_dread  <= '0;
            a_done   <= 1'b0;
            b_done   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        state   <= ST_BUSY;
                        m_valid <= 1'b1;
                        gnt_q   <= pick;
                        ptr     <= other_req(pick);
                        if (pick == REQ_B) begin
                            m_rw     <= b_rw;
                            m_addr   <= b_addr;
                            m_dwrite <= b_dwrite;
                        end else begin
                            m_rw     <= a_rw;
                            m_addr   <= a_addr;
                            m_dwrite <= a_dwrite;
                        end
                    end
                end
                ST_BUSY: begin
                    // m_done cannot be seen on the grant edge: we were still in IDLE then.
                    if (m_done) begin
                        state   <= ST_DONE;
                        m_valid <= 1'b0;
                        if (gnt_q == REQ_B) begin
                            b_done <= 1'b1;
                            if (!m_rw) b_dread <= m_dread;
                        end else begin
                            a_done <= 1'b1;
                            if (!m_rw) a_dread <= m_dread;
                        end
                    end
                end
                ST_DONE: begin
                    a_done <= 1'b0;
                    b_done <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_soc_bram_arb.sv
// Bench for soc_bram_arb: behavioural BRAM responder plus a transaction-level arbitration model.
module tb_soc_bram_arb;

    typedef struct {
        logic        rw;
        logic [7:0]  addr;
        logic [31:0] dat;
    } req_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        a_valid = 1'b0, a_rw = 1'b0, b_valid = 1'b0, b_rw = 1'b0;
    logic [7:0]  a_addr = '0, b_addr = '0;
    logic [31:0] a_dwrite = '0, b_dwrite = '0;
    logic [31:0] a_dread, b_dread;
    logic        a_done, b_done;
    logic        m_valid, m_rw;
    logic [7:0]  m_addr;
    logic [31:0] m_dwrite;
    logic [31:0] m_dread = '0;
    logic        m_done = 1'b0;

    int ntests = 0;
    int nfail  = 0;

    logic hold = 1'b0;
    logic spur_req = 1'b0;

    logic [31:0] ref_mem [256];
    logic [31:0] exp_ad = '0, exp_bd = '0;
    logic        exp_ptr = 1'b0;
    req_t        qa[$], qb[$];

    int cyc_cnt = 0, mv_rises = 0, last_rise = 0, min_gap = 1000;
    int a_run = 0, b_run = 0, a_maxw = 0, b_maxw = 0, a_pulses = 0, b_pulses = 0;
    bit mv_prev = 1'b0, have_last = 1'b0;

    soc_bram_arb #(.addr_width(8), .data_width(32)) dut (
        .clk(clk), .rstn(rstn),
        .a_valid(a_valid), .a_rw(a_rw), .a_addr(a_addr), .a_dwrite(a_dwrite),
        .a_dread(a_dread), .a_done(a_done),
        .b_valid(b_valid), .b_rw(b_rw), .b_addr(b_addr), .b_dwrite(b_dwrite),
        .b_dread(b_dread), .b_done(b_done),
        .m_valid(m_valid), .m_rw(m_rw), .m_addr(m_addr), .m_dwrite(m_dwrite),
        .m_dread(m_dread), .m_done(m_done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input int i);
        return 32'h5A00_0000 ^ (32'(i) * 32'h0101_0101);
    endfunction

    // Stand-in for soc_bram_ctl: random 1..4 cycle latency, one-cycle done pulse.
    initial begin
        logic [31:0] mem [256];
        int wcnt;
        for (int i = 0; i < 256; i++) mem[i] = init_val(i);
        wcnt = -1;
        forever begin
            @(posedge clk);
            #1;
            if (!rstn) begin
                m_done = 1'b0;
                wcnt = -1;
            end else if (m_done) begin
                m_done = 1'b0;
            end else if (spur_req) begin
                m_dread = 32'hFFFF_FFFF;
                m_done  = 1'b1;
            end else if (m_valid && !hold) begin
                if (wcnt < 0) wcnt = $urandom_range(0, 3);
                if (wcnt == 0) begin
                    if (m_rw) mem[m_addr] = m_dwrite;
                    else      m_dread = mem[m_addr];
                    m_done = 1'b1;
                    wcnt = -1;
                end else begin
                    wcnt--;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            cyc_cnt++;
            if (!rstn) have_last = 1'b0;
            if (m_valid && !mv_prev) begin
                mv_rises++;
                if (have_last && (cyc_cnt - last_rise) < min_gap) min_gap = cyc_cnt - last_rise;
                last_rise = cyc_cnt;
                have_last = rstn;
            end
            mv_prev = m_valid;
            if (a_done && a_run == 0) a_pulses++;
            if (b_done && b_run == 0) b_pulses++;
            a_run = a_done ? a_run + 1 : 0;
            b_run = b_done ? b_run + 1 : 0;
            if (a_run > a_maxw) a_maxw = a_run;
            if (b_run > b_maxw) b_maxw = b_run;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        ntests++;
        assert (obs === exp_v) else begin
            nfail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp_v);
        end
    endtask

    function automatic req_t rnd_req();
        req_t r;
        r.rw   = 1'($urandom_range(0, 1));
        r.addr = 8'(8'h80 + $urandom_range(0, 7));
        r.dat  = $urandom;
        return r;
    endfunction

    function automatic req_t mk(input logic rw, input logic [7:0] addr, input logic [31:0] dat);
        req_t r;
        r.rw = rw; r.addr = addr; r.dat = dat;
        return r;
    endfunction

    task automatic present_a();
        a_valid = 1'b1; a_rw = qa[0].rw; a_addr = qa[0].addr; a_dwrite = qa[0].dat;
    endtask

    task automatic present_b();
        b_valid = 1'b1; b_rw = qb[0].rw; b_addr = qb[0].addr; b_dwrite = qb[0].dat;
    endtask

    // Runs everything queued in qa/qb; completing side presents its next request in its done cycle.
    task automatic run_queues(input string tag);
        int   order[$];
        int   na, nb, n, done_n, cyc, rises0;
        bit   p;
        req_t r;
        na = qa.size(); nb = qb.size(); p = exp_ptr;
        while (na > 0 || nb > 0) begin
            int w;
            w = (na > 0 && nb > 0) ? int'(p) : ((na > 0) ? 0 : 1);
            order.push_back(w);
            p = (w == 0);
            if (w == 0) na--; else nb--;
        end
        exp_ptr = p;
        n = order.size();
        rises0 = mv_rises;
        done_n = 0;
        cyc = 0;
        if (qa.size() > 0) present_a();
        if (qb.size() > 0) present_b();
        while (done_n < n && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (a_done) begin
                chk({tag, "_order"}, 32'(0), 32'(order[done_n]));
                r = qa.pop_front();
                if (r.rw) ref_mem[r.addr] = r.dat; else exp_ad = ref_mem[r.addr];
                chk({tag, "_a_dread"}, a_dread, exp_ad);
                chk({tag, "_b_dread_idle"}, b_dread, exp_bd);
                chk({tag, "_b_done_idle"}, 32'(b_done), 32'(0));
                done_n++;
                if (qa.size() > 0) present_a(); else a_valid = 1'b0;
            end
            if (b_done) begin
                chk({tag, "_order"}, 32'(1), 32'(order[done_n]));
                r = qb.pop_front();
                if (r.rw) ref_mem[r.addr] = r.dat; else exp_bd = ref_mem[r.addr];
                chk({tag, "_b_dread"}, b_dread, exp_bd);
                chk({tag, "_a_dread_idle"}, a_dread, exp_ad);
                done_n++;
                if (qb.size() > 0) present_b(); else b_valid = 1'b0;
            end
        end
        chk({tag, "_completions"}, 32'(done_n), 32'(n));
        chk({tag, "_grants"}, 32'(mv_rises - rises0), 32'(n));
        qa.delete();
        qb.delete();
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic wait_mvalid(input string tag);
        int k;
        k = 0;
        while (!m_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(m_valid), 32'(1));
    endtask

    initial begin
        int pa, pb;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);

        repeat (3) @(negedge clk);
        chk("rst_m_valid", 32'(m_valid), 32'(0));
        chk("rst_m_rw", 32'(m_rw), 32'(0));
        chk("rst_m_addr", 32'(m_addr), 32'(0));
        chk("rst_m_dwrite", m_dwrite, 32'(0));
        chk("rst_a_dread", a_dread, 32'(0));
        chk("rst_b_dread", b_dread, 32'(0));
        chk("rst_dones", 32'({a_done, b_done}), 32'(0));
        rstn = 1'b1;
        @(negedge clk);

        qa.push_back(mk(1'b1, 8'h80, 32'h1122_3344));
        run_queues("basic_wr");
        qb.push_back(mk(1'b0, 8'h80, 32'h0));
        run_queues("basic_rd");
        chk("basic_b_dread_val", b_dread, 32'h1122_3344);
        chk("basic_a_dread_zero", a_dread, 32'h0);

        qa.push_back(mk(1'b0, 8'h82, 32'h0));
        qb.push_back(mk(1'b1, 8'h82, 32'hDEAD_BEEF));
        run_queues("simul");
        chk("simul_a_pre", a_dread, init_val(8'h82));
        qa.push_back(mk(1'b0, 8'h82, 32'h0));
        run_queues("simul_rb");
        chk("simul_a_post", a_dread, 32'hDEAD_BEEF);

        for (int i = 0; i < 3; i++) begin
            qa.push_back(rnd_req());
            qb.push_back(rnd_req());
        end
        run_queues("fair");

        pa = a_pulses;
        for (int i = 0; i < 4; i++) qb.push_back(mk(1'b0, 8'(8'h80 + i), 32'h0));
        run_queues("stream");
        chk("stream_no_a_done", 32'(a_pulses), 32'(pa));

        @(negedge clk);
        hold = 1'b1;
        a_valid = 1'b1; a_rw = 1'b0; a_addr = 8'h84;
        wait_mvalid("rst_mid_busy");
        a_valid = 1'b0;
        b_valid = 1'b1; b_rw = 1'b0; b_addr = 8'h85;
        #2 rstn = 1'b0;
        #1;
        chk("rst_mid_m_valid", 32'(m_valid), 32'(0));
        chk("rst_mid_dones", 32'({a_done, b_done}), 32'(0));
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_b_first_edge", 32'(m_valid), 32'(1));
        chk("rst_b_first_addr", 32'(m_addr), 32'(8'h85));
        rstn = 1'b0;
        b_valid = 1'b0;
        a_valid = 1'b1; a_addr = 8'h84;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_a_grant_addr", 32'(m_addr), 32'(8'h84));
        rstn = 1'b0;
        a_valid = 1'b1; a_addr = 8'h86;
        b_valid = 1'b1; b_addr = 8'h87;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_ptr_is_a", 32'(m_addr), 32'(8'h86));
        rstn = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        @(negedge clk);
        hold = 1'b0;
        rstn = 1'b1;
        exp_ptr = 1'b0; exp_ad = '0; exp_bd = '0;
        @(negedge clk);
        chk("rst_clean_dreads", a_dread | b_dread, 32'(0));

        for (int k = 0; k < 6; k++) begin
            int la, lb;
            la = $urandom_range(0, 3);
            lb = $urandom_range(0, 3);
            for (int i = 0; i < la; i++) qa.push_back(rnd_req());
            for (int i = 0; i < lb; i++) qb.push_back(rnd_req());
            run_queues("rand");
        end

        repeat (2) @(negedge clk);
        pa = a_pulses;
        pb = b_pulses;
        spur_req = 1'b1;
        @(negedge clk);
        spur_req = 1'b0;
        repeat (4) @(negedge clk);
        chk("spur_a_done", 32'(a_pulses), 32'(pa));
        chk("spur_b_done", 32'(b_pulses), 32'(pb));
        chk("spur_a_dread", a_dread, exp_ad);
        chk("spur_b_dread", b_dread, exp_bd);
        chk("spur_m_valid", 32'(m_valid), 32'(0));

        chk("grant_gap_min3", 32'(min_gap >= 3), 32'(1));
        chk("a_done_width", 32'(a_maxw), 32'(1));
        chk("b_done_width", 32'(b_maxw), 32'(1));

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/soc_bram_arb.md
Name: soc_bram_arb

Overview:
Two-port round-robin arbiter that shares one soc_bram_ctl instance between requester A (instruction fetch) and requester B (data/load-store). It accepts one transaction at a time, forwards it to the controller's valid/rw/addr/dwrite interface and waits for done. It then returns read data and a done pulse to the granted requester. It sits between the core bus masters and soc_bram_ctl.

Parameters:
addr_width, 8, address width, passed through unchanged to soc_bram_ctl.
data_width, 32, data word width; must equal soc_bram_ctl data width.

Ports:
clk  in  1  system clock, all state on posedge
rstn  in  1  asynchronous active-low reset
a_valid  in  1  requester A request; held high until a_done
a_rw  in  1  1=write, 0=read
a_addr  in  addr_width  requester A address
a_dwrite  in  data_width  requester A write data
a_dread  out  data_width  requester A read data, valid while a_done=1 and held after
a_done  out  1  one-cycle completion pulse to A
b_valid, b_rw, b_addr, b_dwrite, b_dread, b_done  same widths and meaning for requester B
m_valid  out  1  to soc_bram_ctl valid
m_rw  out  1  to soc_bram_ctl rw
m_addr  out  addr_width  to soc_bram_ctl addr
m_dwrite  out  data_width  to soc_bram_ctl dwrite
m_dread  in  data_width  from soc_bram_ctl dread
m_done  in  1  from soc_bram_ctl done; one-cycle pulse

Behaviour:
- Reset (rstn low, async): state=IDLE. m_valid, a_done and b_done are 0. m_rw, m_addr, m_dwrite, a_dread and b_dread are 0. Priority pointer selects A. An in-flight controller op is abandoned; any m_done arriving after reset release while in IDLE is ignored.
- States: IDLE, BUSY, DONE.
- IDLE: sample a_valid and b_valid each edge.
  - Neither valid: stay in IDLE.
  - Exactly one valid: grant that requester.
  - Both valid: grant the requester indicated by the pointer.
  - On grant: latch rw/addr/dwrite into m_* regs, set m_valid=1, record grant, go to BUSY. The pointer flips to the non-granted requester.
- BUSY: m_valid and m_* held stable. m_done ignored on the grant edge itself, i.e. the earliest accepted is the next edge.
  - On m_done=1: m_valid<=0. If the op was a read, the granted requester's dread<=m_dread. Writes leave dread unchanged. The granted requester's done<=1. Go to DONE.
- DONE: done pulse visible for exactly this one cycle; both valids ignored. Next edge: done<=0, go to IDLE.
- Requester obligation: deassert valid, or present a new request, in the cycle done is high. The earliest re-sample is in the following IDLE.
- Latency: request sampled at edge E0 → m_valid high after E0 → m_done at edge Ek (k≥1) → requester done high for cycle Ek..Ek+1.
  - Minimum gap between consecutive grants is 3 edges.
  - m_valid is low for at least one cycle between transactions.
- Request inputs may change while not granted. Inputs after grant are don't-care because they are latched.
- The non-granted requester's done never pulses and its dread never changes.
- m_done while in IDLE or DONE: ignored, no output change.
- Widths: all data paths are pass-through. No arithmetic. m_addr is exactly addr_width.

Decomposition:
- Shared package soc_bram_pkg:
  - State encoding: IDLE=2'd0, BUSY=2'd1, DONE=2'd2.
  - Requester index constants: REQ_A=1'b0, REQ_B=1'b1.
- One sub-module is natural: soc_rr_arb2. It is a combinational 2-way round-robin grant picker. Inputs: valids and pointer. Outputs: grant and any-grant. It is reusable for other shared SoC resources.
- Pointer register and FSM stay in soc_bram_arb.

Test Plan:
- Basic write/read. Drive soc_bram_ctl with addr_width=8. A writes 0x1122_3344 to 0x80 and gets a_done. B then reads 0x80 → b_done pulses once and b_dread=0x1122_3344. a_dread is unchanged (0).
- Simultaneous requests. After reset, A reads 0x82 and B writes 0xDEAD_BEEF to 0x82 in the same cycle → A granted first, so a_dread equals the pre-write contents. B is granted after A's DONE. A later read of 0x82 returns 0xDEAD_BEEF.
- Fairness. A and B both hold valid continuously for 6 transactions → grant order is A,B,A,B,A,B. m_valid is low for at least one cycle between each pair, and each done is exactly 1 cycle wide.
- Single requester streaming. Only B is valid, with 4 back-to-back reads at 0x80,0x81,0x82,0x83 → 4 b_done pulses. Each is ≥3 edges after the previous grant. a_done stays 0 throughout.
- Reset mid-operation. Drop rstn while in BUSY with m_valid=1 → m_valid, a_done and b_done are 0 immediately (async). After release: state=IDLE, pointer=A, and a pending b_valid is granted on the first edge.
- Spurious m_done. Inject m_done=1 while in IDLE → no done pulse and no dread change.
